// File: rtl/layer_serial_pkg.sv
// layer_serial_pkg: shared state type and elaboration helpers for the serial layer
package layer_serial_pkg;
  typedef enum logic {S_FILL, S_BUSY} in_state_t;
  function automatic int clog2_1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic string mif_name(input string prefix, input int layer, input int idx);
    return $sformatf("%s_%0d_%0d.mif", prefix, layer, idx);
  endfunction
endpackage

// File: rtl/layer_out_buf.sv
// layer_out_buf: stage/obuf double buffer re-serialised one word per cycle under valid/ready
module layer_out_buf #(
  parameter int N  = 10,
  parameter int DW = 16,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_stage_we,
  input  logic [N*DW-1:0] i_stage_d,
  input  logic          i_capture,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic [IW-1:0] o_idx,
  output logic          o_last,
  output logic          o_drain_done
);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  logic [DW-1:0] r_stage [N];
  logic [DW-1:0] r_obuf [N];
  logic r_full;
  logic [IW-1:0] r_idx;
  logic w_beat;
  // stage each neuron result as its pulse arrives; a repeat pulse simply overwrites
  always_ff @(posedge clk) begin
    for (int n = 0; n < N; n++) if (i_stage_we[n]) r_stage[n] <= i_stage_d[n*DW +: DW];
  end
  // capture wins over the drain step; the last handshake empties the buffer
  always_ff @(posedge clk) begin
    if (i_capture) r_obuf <= r_stage;
    if (rst) begin
      r_full <= 1'b0;
      r_idx <= '0;
    end else if (i_capture) begin
      r_full <= 1'b1;
      r_idx <= '0;
    end else if (w_beat) begin
      r_full <= !o_last;
      r_idx <= o_last ? '0 : r_idx + 1'b1;
    end
  end
  assign w_beat = r_full && i_out_ready;
  assign o_valid = r_full;
  assign o_data = r_obuf[r_idx];
  assign o_idx = r_idx;
  assign o_last = r_full && (r_idx == LAST);
  assign o_drain_done = w_beat && o_last;
endmodule

// File: rtl/neuron.sv
// neuron: serial multiply-accumulate neuron with runtime-loaded weights, bias and optional activation
module neuron
  import layer_serial_pkg::*;
#(
  parameter int    layer_no                = 0,
  parameter int    neuron_no               = 0,
  parameter int    num_weights             = 30,
  parameter int    data_width              = 16,
  parameter int    weight_sigmoid_in_width = 10,
  parameter int    weightintwidht          = 4,
  parameter string activation              = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] my_input,
  input  logic                  valid_input,
  input  logic [31:0]           weight_value,
  input  logic                  valid_weight,
  input  logic [31:0]           bias_value,
  input  logic                  valid_bias,
  input  logic [31:0]           layer_layer_no,
  input  logic [31:0]           neuron_neuron_no,
  output logic [data_width-1:0] neuron_out,
  output logic                  valid_output
);
  localparam int CW = clog2_1(num_weights);
  localparam int AW = data_width + 32 + CW + 1;
  localparam int FRAC = data_width - weightintwidht;
  localparam logic [CW-1:0] LAST = CW'(num_weights - 1);
  localparam logic signed [AW-1:0] SMAX = {{(AW-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  localparam logic signed [data_width-1:0] XMAX = data_width'((1 << (weight_sigmoid_in_width - 1)) - 1);
  localparam logic signed [data_width-1:0] XMIN = ~XMAX;
  localparam logic signed [data_width-1:0] HALF = data_width'(1 << (FRAC - 1));
  localparam bit IS_RELU = (activation == "relu");
  localparam bit IS_SIGM = (activation == "sigmoid");
  logic signed [31:0] r_w [num_weights];
  logic signed [31:0] r_bias;
  logic [CW-1:0] r_wptr, r_cnt;
  logic signed [AW-1:0] r_acc;
  logic r_fire;
  logic w_sel;
  logic signed [AW-1:0] w_prod, w_sum, w_scaled;
  logic signed [data_width-1:0] w_sat, w_x, w_act;
  assign w_sel = (layer_layer_no == 32'(layer_no)) && (neuron_neuron_no == 32'(neuron_no));
  assign w_prod = AW'($signed(my_input)) * AW'(r_w[r_cnt]);
  assign w_sum = r_acc + AW'(r_bias);
  assign w_scaled = w_sum >>> FRAC;
  assign w_sat = (w_scaled > SMAX) ? SMAX[data_width-1:0] : (w_scaled < SMIN) ? SMIN[data_width-1:0] : w_scaled[data_width-1:0];
  assign w_x = (w_sat > XMAX) ? XMAX : (w_sat < XMIN) ? XMIN : w_sat;
  assign w_act = IS_RELU ? (w_sat[data_width-1] ? '0 : w_sat) : IS_SIGM ? (w_x >>> 2) + HALF : w_sat;
  // weight/bias load: every neuron sees the broadcast and keeps only its own address
  always_ff @(posedge clk) begin
    if (rst) r_wptr <= '0;
    else if (valid_weight && w_sel) r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
    if (valid_weight && w_sel) r_w[r_wptr] <= weight_value;
    if (valid_bias && w_sel) r_bias <= bias_value;
  end
  // accumulate the serial vector, then emit the activated result one cycle after its last element
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_fire <= 1'b0;
      valid_output <= 1'b0;
      neuron_out <= '0;
    end else begin
      r_fire <= valid_input && (r_cnt == LAST);
      valid_output <= r_fire;
      if (r_fire) neuron_out <= w_act;
      if (valid_input) begin
        r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        r_acc <= (r_fire ? '0 : r_acc) + w_prod;
      end else if (r_fire) r_acc <= '0;
    end
  end
endmodule

// File: rtl/layer_serial.sv
// layer_serial: fully-connected layer of serial neurons sharing one input stream, results re-serialised
module layer_serial
  import layer_serial_pkg::*;
#(
  parameter int    no_neuron               = 10,
  parameter int    num_weights             = 30,
  parameter int    data_width              = 16,
  parameter int    layer_no                = 3,
  parameter int    weight_sigmoid_in_width = 10,
  parameter int    weightintwidht          = 4,
  parameter string activation              = "",
  localparam int   IW                      = clog2_1(no_neuron)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           weight_value,
  input  logic                  valid_weight,
  input  logic [31:0]           bias_value,
  input  logic                  valid_bias,
  input  logic [31:0]           layer_layer_no,
  input  logic [31:0]           neuron_neuron_no,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IW-1:0]         out_idx,
  output logic                  out_last,
  output logic                  err_overrun
);
  localparam int CW = clog2_1(num_weights);
  localparam logic [CW-1:0] LAST = CW'(num_weights - 1);
  in_state_t r_state, w_state_nx;
  logic [CW-1:0] r_in_cnt;
  logic [no_neuron-1:0] r_mask, w_vout;
  logic [no_neuron*data_width-1:0] w_nout;
  logic r_err;
  logic w_xfer, w_capture, w_drain_done;
  assign in_ready = (r_state == S_FILL);
  assign w_xfer = in_valid && in_ready;
  assign w_capture = (&r_mask) && (!out_valid || w_drain_done);
  assign err_overrun = r_err;
  // input side: count elements and hold off further input until the result is captured
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
      r_in_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_xfer) r_in_cnt <= (r_in_cnt == LAST) ? '0 : r_in_cnt + 1'b1;
    end
  end
  // next state: the last element makes the layer busy, capture frees it
  always_comb begin
    w_state_nx = (r_state == S_FILL && w_xfer && r_in_cnt == LAST) ? S_BUSY :
                 (r_state == S_BUSY && w_capture) ? S_FILL : r_state;
  end
  // collect neuron pulses; a pulse on a bit still set is a sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
      r_err <= 1'b0;
    end else begin
      r_mask <= (w_capture ? '0 : r_mask) | w_vout;
      r_err <= r_err || (|(r_mask & w_vout));
    end
  end
  for (genvar n = 0; n < no_neuron; n++) begin : g_n
    neuron #(
      .layer_no(layer_no), .neuron_no(n + 1), .num_weights(num_weights), .data_width(data_width),
      .weight_sigmoid_in_width(weight_sigmoid_in_width), .weightintwidht(weightintwidht),
      .activation(activation)
    ) u_neuron (
      .clk(clk), .rst(rst), .my_input(in_data), .valid_input(w_xfer),
      .weight_value(weight_value), .valid_weight(valid_weight),
      .bias_value(bias_value), .valid_bias(valid_bias),
      .layer_layer_no(layer_layer_no), .neuron_neuron_no(neuron_neuron_no),
      .neuron_out(w_nout[n*data_width +: data_width]), .valid_output(w_vout[n])
    );
  end
  layer_out_buf #(.N(no_neuron), .DW(data_width), .IW(IW)) u_obuf (
    .clk(clk), .rst(rst), .i_stage_we(w_vout), .i_stage_d(w_nout), .i_capture(w_capture),
    .i_out_ready(out_ready), .o_data(out_data), .o_valid(out_valid), .o_idx(out_idx),
    .o_last(out_last), .o_drain_done(w_drain_done)
  );
endmodule

// File: tb/tb_layer_serial.sv
// tb_layer_serial: directed self-checking bench for the serial layer (10x30 and 1x4 instances)
module tb_layer_serial;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] in_data = '0, in_data2 = '0;
  logic in_valid = 1'b0, in_valid2 = 1'b0, in_ready, in_ready2;
  logic [31:0] weight_value = '0, bias_value = '0, layer_layer_no = '0, neuron_neuron_no = '0;
  logic valid_weight = 1'b0, valid_bias = 1'b0;
  logic [15:0] out_data, out_data2;
  logic out_valid, out_valid2, out_ready = 1'b0, out_ready2 = 1'b0;
  logic [3:0] out_idx;
  logic [0:0] out_idx2;
  logic out_last, out_last2, err_overrun, err2;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  layer_serial dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .weight_value(weight_value), .valid_weight(valid_weight), .bias_value(bias_value),
    .valid_bias(valid_bias), .layer_layer_no(layer_layer_no), .neuron_neuron_no(neuron_neuron_no),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .err_overrun(err_overrun)
  );

  layer_serial #(.no_neuron(1), .num_weights(4)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .weight_value(weight_value), .valid_weight(valid_weight), .bias_value(bias_value),
    .valid_bias(valid_bias), .layer_layer_no(layer_layer_no), .neuron_neuron_no(neuron_neuron_no),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_idx(out_idx2),
    .out_last(out_last2), .err_overrun(err2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // neuron n has all weights (n+1).0 and bias n, so its output is (n+1)*sum + n
  function automatic logic [15:0] expv(input int n, input int s);
    return 16'((n + 1) * s + n);
  endfunction

  function automatic logic [15:0] vv(input int mode, input int i);
    return (mode == 0) ? 16'(i + 1) : (mode == 1) ? 16'd2 : 16'hFFFF;
  endfunction

  task automatic send_vec(input int mode, input string tag);
    for (int i = 0; i < 30; i++) begin
      check({tag, "_in_ready"}, 32'(in_ready), 1);
      in_data = vv(mode, i);
      in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    check({tag, "_in_ready_low"}, 32'(in_ready), 0);
  endtask

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick;
      cyc++;
    end
    check({tag, "_out_valid_rise"}, 32'(out_valid), 1);
  endtask

  task automatic drain(input int s, input string tag);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check({tag, "_valid"}, 32'(out_valid), 1);
      check({tag, "_idx"}, 32'(out_idx), 32'(k));
      check({tag, "_data"}, 32'(out_data), 32'(expv(k, s)));
      check({tag, "_last"}, 32'(out_last), 32'(k == 9));
      tick;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, k, sent, got;
    logic pat [4];
    logic acc;
    logic [15:0] exp2 [2];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp2 = '{16'd10, 16'd26};
    tick;
    tick;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_err", 32'(err_overrun), 0);
    check("rst2_out_last", 32'(out_last2), 0);
    check("rst2_in_ready", 32'(in_ready2), 1);
    layer_layer_no = 32'd3;
    for (int n = 0; n < 10; n++) begin
      neuron_neuron_no = 32'(n + 1);
      for (int i = 0; i < 30; i++) begin
        weight_value = 32'((n + 1) << 12);
        valid_weight = 1'b1;
        tick;
      end
      valid_weight = 1'b0;
      bias_value = 32'(n << 12);
      valid_bias = 1'b1;
      tick;
      valid_bias = 1'b0;
    end
    // T1: single vector 1..30 (sum 465), drained at full rate
    send_vec(0, "t1");
    wait_valid("t1", cyc);
    check("t1_latency", 32'(cyc), 3);
    drain(465, "t1");
    check("t1_empty", 32'(out_valid), 0);
    check("t1_in_ready_back", 32'(in_ready), 1);
    // T2: constant 2 (sum 60) under ready pattern 1,0,0,1
    send_vec(1, "t2");
    wait_valid("t2", cyc);
    k = 0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      out_ready = pat[c % 4];
      if (out_valid) begin
        check("t2_idx", 32'(out_idx), 32'(k));
        check("t2_data", 32'(out_data), 32'(expv(k, 60)));
        if (out_ready) k++;
      end
      tick;
    end
    out_ready = 1'b0;
    check("t2_count", 32'(k), 10);
    check("t2_empty", 32'(out_valid), 0);
    // T3: vector B loaded while A sits stalled; B captured on A's last handshake
    send_vec(0, "t3a");
    wait_valid("t3a", cyc);
    send_vec(1, "t3b");
    repeat (6) tick;
    check("t3_hold_valid", 32'(out_valid), 1);
    check("t3_hold_idx", 32'(out_idx), 0);
    check("t3_hold_data", 32'(out_data), 32'(expv(0, 465)));
    check("t3_hold_in_ready", 32'(in_ready), 0);
    drain(465, "t3a_drain");
    check("t3_swap_valid", 32'(out_valid), 1);
    check("t3_swap_idx", 32'(out_idx), 0);
    check("t3_swap_data", 32'(out_data), 32'(expv(0, 60)));
    check("t3_swap_in_ready", 32'(in_ready), 1);
    drain(60, "t3b_drain");
    check("t3_empty", 32'(out_valid), 0);
    // T4: reset at out_idx 4, then a fresh all -1 vector (sum -30)
    send_vec(0, "t4");
    wait_valid("t4", cyc);
    out_ready = 1'b1;
    repeat (4) tick;
    out_ready = 1'b0;
    check("t4_idx_before_rst", 32'(out_idx), 4);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t4_rst_valid", 32'(out_valid), 0);
    check("t4_rst_in_ready", 32'(in_ready), 1);
    check("t4_rst_idx", 32'(out_idx), 0);
    send_vec(2, "t4b");
    wait_valid("t4b", cyc);
    drain(-30, "t4b");
    check("t4_empty", 32'(out_valid), 0);
    // T5: two back-to-back pulses on neuron 2 without a capture
    check("t5_err_clear", 32'(err_overrun), 0);
    force dut.w_vout = 10'b0000000100;
    tick;
    check("t5_err_single", 32'(err_overrun), 0);
    tick;
    release dut.w_vout;
    check("t5_err_set", 32'(err_overrun), 1);
    repeat (5) tick;
    check("t5_err_held", 32'(err_overrun), 1);
    check("t5_no_capture", 32'(out_valid), 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t5_err_rst", 32'(err_overrun), 0);
    // T6: one neuron, four inputs per vector, vectors 1..4 and 5..8 streamed back to back
    sent = 0;
    got = 0;
    out_ready2 = 1'b1;
    for (int c = 0; c < 80 && got < 2; c++) begin
      in_valid2 = (sent < 8);
      in_data2 = 16'(sent + 1);
      acc = in_valid2 && in_ready2;
      if (out_valid2) begin
        check("t6_last", 32'(out_last2), 1);
        check("t6_idx", 32'(out_idx2), 0);
        check("t6_data", 32'(out_data2), 32'(exp2[got]));
        got++;
      end
      tick;
      if (acc) sent++;
    end
    in_valid2 = 1'b0;
    check("t6_sent", 32'(sent), 8);
    check("t6_got", 32'(got), 2);
    tick;
    check("t6_empty", 32'(out_valid2), 0);
    check("t6_err", 32'(err2), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
